// File: rtl/noc_egress_credit_scheduler_if.sv
// rtl/noc_egress_credit_scheduler_if.sv - requester, egress and telemetry signal bundle for the egress credit scheduler
// Parameters: NUM_REQ requesters, FLIT_WIDTH flit bits, CREDIT_MAX credit saturation (CW = $clog2(CREDIT_MAX+1)).
// slave  : scheduler side (takes requests/ready/credits, drives grants, egress flit and telemetry)
// master : environment side (requesters, downstream link, telemetry consumer)
interface noc_egress_credit_scheduler_if #(
    parameter int NUM_REQ    = 5,
    parameter int FLIT_WIDTH = 64,
    parameter int CREDIT_MAX = 15
);
    localparam int CW = $clog2(CREDIT_MAX + 1);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FLIT_WIDTH-1:0] req_flit;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_prio;
    logic [FLIT_WIDTH-1:0]         flit_out;
    logic                          valid_out;
    logic                          ready_in;
    logic                          credit_in;
    logic [CW-1:0]                 credit_level;
    logic                          credit_overflow;
    logic [31:0]                   flits_out_count;
    logic [31:0]                   stall_bp_count;
    logic [31:0]                   stall_arb_count;

    modport slave (
        input  req_valid, req_flit, req_prio, ready_in, credit_in,
        output req_ready, flit_out, valid_out, credit_level, credit_overflow,
               flits_out_count, stall_bp_count, stall_arb_count
    );

    modport master (
        output req_valid, req_flit, req_prio, ready_in, credit_in,
        input  req_ready, flit_out, valid_out, credit_level, credit_overflow,
               flits_out_count, stall_bp_count, stall_arb_count
    );
endinterface

// File: rtl/noc_egress_credit_scheduler.sv
// rtl/noc_egress_credit_scheduler.sv - round-robin, credit-gated router egress scheduler with telemetry counters
// Ports: clk, reset (synchronous, active-high), sched (noc_egress_credit_scheduler_if.slave):
//   req_valid/req_flit/req_ready/req_prio requester side, flit_out/valid_out/ready_in/credit_in egress side,
//   credit_level/credit_overflow/flits_out_count/stall_bp_count/stall_arb_count telemetry.
// Optional feature macro: NOC_SCHED_PRIO_EN (two-level priority arbitration; default build is pure round-robin).
module noc_egress_credit_scheduler #(
    parameter int NUM_REQ     = 5,
    parameter int FLIT_WIDTH  = 64,
    parameter int CREDIT_INIT = 2,
    parameter int CREDIT_MAX  = 15
) (
    input logic clk,
    input logic reset,
    noc_egress_credit_scheduler_if.slave sched
);
    localparam int CW = $clog2(CREDIT_MAX + 1);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CW-1:0] CRED_MAX_V  = CW'(CREDIT_MAX);
    localparam logic [CW-1:0] CRED_INIT_V = CW'(CREDIT_INIT);
    localparam logic [IW:0]   NUM_REQ_V   = (IW + 1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX    = IW'(NUM_REQ - 1);

    logic                  hold_v;
    logic [FLIT_WIDTH-1:0] hold_flit;
    logic [CW-1:0]         credit_cnt;
    logic [IW-1:0]         rr_ptr;
    logic                  overflow;
    logic [31:0]           flits_cnt;
    logic [31:0]           bp_cnt;
    logic [31:0]           arb_cnt;

    logic                  fire;
    logic                  load_en;
    logic                  grant_any;
    logic [IW-1:0]         grant_idx;
    logic [NUM_REQ-1:0]    cand;
    logic [NUM_REQ-1:0]    grant;
    logic [FLIT_WIDTH-1:0] grant_flit;

    // valid_out depends only on registered state, so ready_in/credit_in never reach it combinationally.
    assign fire    = hold_v & sched.ready_in & (credit_cnt != '0);
    assign load_en = ~hold_v | fire;

    // Candidate set for the round-robin search.
`ifdef NOC_SCHED_PRIO_EN
    always_comb begin
        cand = sched.req_valid;
        if ((sched.req_valid & sched.req_prio) != '0) begin
            cand = sched.req_valid & sched.req_prio;
        end
    end
`else
    logic prio_unused;
    assign prio_unused = ^sched.req_prio;

    always_comb begin
        cand = sched.req_valid;
    end
`endif

    // Search upward from rr_ptr with wrap; first candidate found wins.
    always_comb begin : arb
        logic [IW:0] pos;
        pos       = '0;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = {1'b0, rr_ptr} + (IW + 1)'(k);
            if (pos >= NUM_REQ_V) begin
                pos = pos - NUM_REQ_V;
            end
            if (load_en && !grant_any && cand[pos[IW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = pos[IW-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        grant_flit = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_flit = sched.req_flit[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
    end

    function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input logic en);
        return (en && cnt != 32'hFFFF_FFFF) ? cnt + 32'd1 : cnt;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v     <= 1'b0;
            hold_flit  <= '0;
            credit_cnt <= CRED_INIT_V;
            rr_ptr     <= '0;
            overflow   <= 1'b0;
            flits_cnt  <= '0;
            bp_cnt     <= '0;
            arb_cnt    <= '0;
        end else begin
            // Refill in the same cycle the register drains.
            if (load_en) begin
                if (grant_any) begin
                    hold_v    <= 1'b1;
                    hold_flit <= grant_flit;
                    rr_ptr    <= (grant_idx == LAST_IDX) ? '0 : grant_idx + 1'b1;
                end else begin
                    hold_v    <= 1'b0;
                end
            end

            // A fire and a credit return in the same cycle cancel out.
            if (sched.credit_in && !fire) begin
                if (credit_cnt == CRED_MAX_V) begin
                    overflow   <= 1'b1;
                end else begin
                    credit_cnt <= credit_cnt + 1'b1;
                end
            end else if (!sched.credit_in && fire) begin
                credit_cnt <= credit_cnt - 1'b1;
            end

            flits_cnt <= sat_inc(flits_cnt, fire);
            bp_cnt    <= sat_inc(bp_cnt, hold_v & ~fire);
            arb_cnt   <= sat_inc(arb_cnt, (sched.req_valid & ~grant) != '0);
        end
    end

    assign sched.req_ready       = grant;
    assign sched.flit_out        = hold_flit;
    assign sched.valid_out       = hold_v & (credit_cnt != '0);
    assign sched.credit_level    = credit_cnt;
    assign sched.credit_overflow = overflow;
    assign sched.flits_out_count = flits_cnt;
    assign sched.stall_bp_count  = bp_cnt;
    assign sched.stall_arb_count = arb_cnt;
endmodule
